// File: rtl/cellram_burst_ctrl.sv
// Synchronous-burst read/write controller for the CellularRAM with WAIT-driven stalls.
// Optional macro CELLRAM_BCR_INIT_EN: write BCR_VALUE to the bus configuration register during INIT.
module cellram_burst_ctrl #(
  parameter int          DW        = 16,
  parameter int          AW        = 23,
  parameter int          BURST_LEN = 4,
  parameter int          LATENCY   = 3,
  parameter logic [19:0] BCR_VALUE = 20'h0_8590
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [AW-1:0] ReqAddr,
  input  logic [DW-1:0] WrData,
  input  logic          WrValid,
  output logic          WrReady,
  output logic [DW-1:0] RdData,
  output logic          RdValid,
  output logic          Done,
  output logic          ConClk,
  output logic          ConCE,
  output logic          ConWE,
  output logic          ConOE,
  output logic          ConADV,
  output logic          ConLB,
  output logic          ConUB,
  output logic          ConCRE,
  output logic [AW-1:0] ConAddr,
  output logic [DW-1:0] ConDataOut,
  output logic          ConDataOE,
  input  logic [DW-1:0] ConDataIn,
  input  logic          ConWait
);

  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ADDR, S_LAT, S_DATA, S_END} stateT;

  stateT         state, nextState;
  logic [2:0]    latCnt;
  logic [BW-1:0] beat;
  logic          isWrite;
  logic [AW-1:0] addrReg;
  logic [DW-1:0] rdDataP1;
  logic          rdVldP1;
  logic          clkGateEn;

  logic          accept, latLast, dataPhase, rdGo, wrGo, beatGo, beatLast;
  logic          initDone, initCrePhase, initWrPhase;
  logic [AW-1:0] burstAddr;

  assign accept    = (state == S_IDLE) && ReqValid;
  assign latLast   = (state == S_LAT) && (latCnt == 3'd0);
  // The first write word goes out in the final latency cycle, so it counts as a data beat.
  assign dataPhase = (state == S_DATA) || latLast;
  assign rdGo      = (state == S_DATA) && !isWrite && !ConWait;
  assign wrGo      = dataPhase && isWrite && !ConWait && WrValid;
  assign beatGo    = rdGo || wrGo;
  assign beatLast  = (beat == BW'(BURST_LEN - 1));
  // Low address bits wrap inside the BURST_LEN block, as the device does in wrap mode.
  assign burstAddr = {addrReg[AW-1:BW], addrReg[BW-1:0] + beat};

`ifdef CELLRAM_BCR_INIT_EN
  logic [2:0] initCnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      initCnt <= 3'd0;
    else if (state == S_INIT && initCnt != 3'd4)
      initCnt <= initCnt + 3'd1;
  end

  // Four strobe cycles of the asynchronous register write, then one CE-high cycle.
  assign initDone     = (initCnt == 3'd4);
  assign initCrePhase = (state == S_INIT) && RST_N;
  assign initWrPhase  = initCrePhase && (initCnt != 3'd4);
`else
  assign initDone     = 1'b1;
  assign initCrePhase = 1'b0;
  assign initWrPhase  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_INIT;
      latCnt  <= 3'd0;
      beat    <= '0;
      isWrite <= 1'b0;
      rdVldP1 <= 1'b0;
    end else begin
      state   <= nextState;
      rdVldP1 <= rdGo;
      if (accept) begin
        isWrite <= ReqWrite;
        latCnt  <= 3'(LATENCY - 1);
        beat    <= '0;
      end else begin
        if (state == S_ADDR || (state == S_LAT && latCnt != 3'd0))
          latCnt <= latCnt - 3'd1;
        if (beatGo)
          beat <= beat + BW'(1);
      end
    end
  end

  // Datapath registers carry no reset; their validity travels in the control flags.
  always_ff @(posedge CLK) begin
    if (accept)
      addrReg <= ReqAddr;
    if (rdGo)
      rdDataP1 <= ConDataIn;
  end

  // Enable changes on the falling edge so the gated memory clock never glitches.
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N)
      clkGateEn <= 1'b0;
    else
      clkGateEn <= (state == S_ADDR) || (state == S_LAT) || (state == S_DATA);
  end

  always_comb begin
    nextState = state;
    ReqReady  = 1'b0;
    WrReady   = 1'b0;
    ConCE     = 1'b1;
    ConWE     = 1'b1;
    ConOE     = 1'b1;
    ConADV    = 1'b1;
    ConLB     = 1'b1;
    ConUB     = 1'b1;
    ConCRE    = 1'b0;
    ConDataOE = 1'b0;
    ConAddr   = '0;
    case (state)
      S_INIT: begin
        ConCRE = initCrePhase;
        if (initCrePhase)
          ConAddr = AW'(BCR_VALUE);
        if (initWrPhase) begin
          ConCE  = 1'b0;
          ConADV = 1'b0;
          ConWE  = 1'b0;
        end
        if (initDone)
          nextState = S_IDLE;
      end
      S_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid)
          nextState = S_ADDR;
      end
      S_ADDR: begin
        ConCE     = 1'b0;
        ConADV    = 1'b0;
        ConWE     = ~isWrite;
        ConLB     = 1'b0;
        ConUB     = 1'b0;
        ConAddr   = burstAddr;
        nextState = S_LAT;
      end
      S_LAT, S_DATA: begin
        ConCE     = 1'b0;
        ConOE     = isWrite;
        ConAddr   = burstAddr;
        // A missing write word is masked off rather than written.
        ConLB     = isWrite && dataPhase && !WrValid;
        ConUB     = isWrite && dataPhase && !WrValid;
        ConDataOE = isWrite && dataPhase;
        WrReady   = wrGo;
        if (state == S_LAT && latLast && !ConWait)
          nextState = S_DATA;
        if (state == S_DATA && beatGo && beatLast)
          nextState = S_END;
      end
      S_END: nextState = S_IDLE;
      default: nextState = S_INIT;
    endcase
  end

  assign Done       = (state == S_END);
  assign RdData     = rdDataP1;
  assign RdValid    = rdVldP1;
  assign ConDataOut = WrData;
  assign ConClk     = CLK & clkGateEn;

endmodule

// File: tb/tb_cellram_burst_ctrl.sv
// Directed bench for cellram_burst_ctrl: read/write bursts, WAIT stalls, write gaps, async reset.
module tb_cellram_burst_ctrl;

  logic        CLK, RST_N;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [22:0] ReqAddr;
  logic [15:0] WrData, RdData, ConDataOut, ConDataIn;
  logic        WrValid, WrReady, RdValid, Done;
  logic        ConClk, ConCE, ConWE, ConOE, ConADV, ConLB, ConUB, ConCRE, ConDataOE, ConWait;
  logic [22:0] ConAddr;

  int nVec = 0;
  int nMis = 0;

  cellram_burst_ctrl #(.DW(16), .AW(23), .BURST_LEN(4), .LATENCY(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
    .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .RdData(RdData), .RdValid(RdValid), .Done(Done),
    .ConClk(ConClk), .ConCE(ConCE), .ConWE(ConWE), .ConOE(ConOE), .ConADV(ConADV),
    .ConLB(ConLB), .ConUB(ConUB), .ConCRE(ConCRE), .ConAddr(ConAddr),
    .ConDataOut(ConDataOut), .ConDataOE(ConDataOE), .ConDataIn(ConDataIn), .ConWait(ConWait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ctrlVec();
    return {ConCE, ConWE, ConOE, ConADV, ConLB, ConUB,
            ConCRE, ConDataOE, ReqReady, WrReady, RdValid, Done};
  endfunction

  // Step negedges until the address cycle shows up (ConADV low), bounded.
  task automatic waitAdv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      #1;
      ok = (ConADV == 1'b0);
    end
    if (!ok) checkVal("advTimeout", 32'd0, 32'd1);
  endtask

  // Issues one burst and records a 12-cycle window starting at the ADV cycle (bit c = cycle c).
  task automatic burst(input logic wr, input logic [22:0] addr,
                       input int waitStart, input int waitLen, input int wrGap,
                       input logic [11:0] eRd, input logic [11:0] eDone,
                       input logic [11:0] eWrRdy, input logic [11:0] eDoe,
                       input logic [11:0] eLbHi, input logic [11:0] eOeLo,
                       input logic [11:0] eRdy);
    logic [11:0] mAdv, mRd, mDone, mWr, mDoe, mLb, mUb, mOe, mRdy;
    int  k, wk;
    bit  ok;
    mAdv = '0; mRd = '0; mDone = '0; mWr = '0; mDoe = '0;
    mLb = '0; mUb = '0; mOe = '0; mRdy = '0;
    k = 0; wk = 0;
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr;
    ConWait = 1'b0; WrValid = wr; WrData = 16'hA001;
    waitAdv(ok);
    ReqValid = 1'b0;
    if (!ok) return;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        #1;
      end
      ConWait = (c >= waitStart) && (c < waitStart + waitLen);
      WrValid = wr && (c != wrGap);
      WrData  = 16'hA001 + 16'(wk);
      #1 ConDataIn = {8'hD0, ConAddr[7:0]};
      #1;
      mAdv[c] = ~ConADV;  mRd[c] = RdValid;  mDone[c] = Done;
      mWr[c]  = WrReady;  mDoe[c] = ConDataOE;
      mLb[c]  = ConLB;    mUb[c] = ConUB;    mOe[c] = ~ConOE;  mRdy[c] = ReqReady;
      if (RdValid) begin
        checkVal("rdData", RdData, {8'hD0, addr[7:0] + 8'(k)});
        k++;
      end
      if (WrReady) begin
        checkVal("wrData", ConDataOut, 16'hA001 + 16'(wk));
        checkVal("wrAddr", ConAddr, addr + 23'(wk));
        wk++;
      end
    end
    WrValid = 1'b0;
    ConWait = 1'b0;
    checkVal("advPulse", mAdv,  12'h001);
    checkVal("rdValid",  mRd,   eRd);
    checkVal("done",     mDone, eDone);
    checkVal("wrReady",  mWr,   eWrRdy);
    checkVal("dataOE",   mDoe,  eDoe);
    checkVal("lbHigh",   mLb,   eLbHi);
    checkVal("ubHigh",   mUb,   eLbHi);
    checkVal("oeLow",    mOe,   eOeLo);
    checkVal("reqReady", mRdy,  eRdy);
  endtask

  initial begin
    bit ok;
    RST_N = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0;
    WrData = '0; WrValid = 1'b0; ConDataIn = '0; ConWait = 1'b0;

    @(negedge CLK);
    #1;
    checkVal("rstCtrl", ctrlVec(), 12'hFC0);
    checkVal("rstAddr", ConAddr, 23'h0);
    RST_N = 1'b1;
    #1 checkVal("initReady", ReqReady, 1'b0);
    @(negedge CLK);
    #1 checkVal("idleReady", ReqReady, 1'b1);

    // Plain read, plain write, read with WAIT at beat 2, write with WrValid gap at beat 1.
    burst(1'b0, 23'h000010, 0, 0, -1, 12'h0F0, 12'h080, 12'h000, 12'h000, 12'hF80, 12'h07E, 12'hF00);
    burst(1'b1, 23'h000020, 0, 0, -1, 12'h000, 12'h040, 12'h03C, 12'h03C, 12'hFC0, 12'h000, 12'hF80);
    burst(1'b0, 23'h000030, 5, 2, -1, 12'h330, 12'h200, 12'h000, 12'h000, 12'hE00, 12'h1FE, 12'hC00);
    burst(1'b1, 23'h000060, 0, 0,  3, 12'h000, 12'h080, 12'h074, 12'h07C, 12'hF88, 12'h000, 12'hF00);

    // Reset in the middle of a read data phase: outputs go idle at once, no Done.
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 23'h000050;
    waitAdv(ok);
    ReqValid = 1'b0;
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    ReqValid = 1'b1; ReqAddr = 23'h000040;
    #1;
    checkVal("rstAsyncCtrl", ctrlVec(), 12'hFC0);
    checkVal("rstAsyncAddr", ConAddr, 23'h0);
    @(negedge CLK);
    #1 checkVal("rstNoDone", Done, 1'b0);
    RST_N = 1'b1;
    #1 checkVal("reInitReady", ReqReady, 1'b0);
    @(negedge CLK);
    #1 checkVal("reIdleReady", ReqReady, 1'b1);
    burst(1'b0, 23'h000040, 0, 0, -1, 12'h0F0, 12'h080, 12'h000, 12'h000, 12'hF80, 12'h07E, 12'hF00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cellram_burst_ctrl.md
Name: cellram_burst_ctrl

Overview:
- Parametrised synchronous-burst controller for the Micron CellularRAM on the NEXYS 3 board.
- Successor to the fixed single-mode burst unit. Adds configurable data/address width, burst length and initial latency, plus both read and write bursts.
- WAIT-driven stall handling and a valid/ready word-stream interface toward the memory arbiter.
- Sits between the arbiter and the board pins. The top level ties ConDataOut/ConDataIn/ConDataOE to the 16-bit inout bus.

Parameters:
- DW, 16, data word width (ConDataIn/Out, WrData, RdData).
- AW, 23, word address width.
- BURST_LEN, 4, words per burst; legal values 4, 8, 16.
- LATENCY, 3, clocks from the ADV rising edge to the first data word; legal range 2..6.
- BCR_VALUE, 20'h0_8590, BCR image written when CELLRAM_BCR_INIT_EN is defined.

Ports:
- CLK  in  1  system clock; also the source of ConClk.
- RST_N  in  1  asynchronous active-low reset.
- ReqValid  in  1  burst request strobe.
- ReqReady  out  1  controller idle; a request is accepted when ReqValid&ReqReady.
- ReqWrite  in  1  1 = write burst, 0 = read burst.
- ReqAddr  in  AW  burst start address; must be BURST_LEN-aligned.
- WrData  in  DW  write word.
- WrValid  in  1  write word available.
- WrReady  out  1  write word consumed this cycle.
- RdData  out  DW  read word.
- RdValid  out  1  RdData valid for one cycle.
- Done  out  1  one-cycle pulse when a burst completes.
- ConClk  out  1  memory clock, equal to CLK gated by the active-chip-enable state.
- ConCE, ConWE, ConOE, ConADV, ConLB, ConUB  out  1 each  active-low memory controls.
- ConCRE  out  1  control-register enable (active high).
- ConAddr  out  AW  memory address.
- ConDataOut  out  DW  write data to the pad.
- ConDataOE  out  1  pad output enable.
- ConDataIn  in  DW  read data from the pad.
- ConWait  in  1  memory WAIT, active high = data not valid.

Behaviour:
- Reset (RST_N low, asynchronous) forces the following, and any burst in progress is abandoned:
  - ConCE, ConWE, ConOE, ConADV, ConLB, ConUB = 1.
  - ConCRE = 0, ConDataOE = 0, ConAddr = 0.
  - ReqReady = 0, WrReady = 0, RdValid = 0, Done = 0.
  - FSM enters INIT.
- INIT: without the optional feature, one cycle, then IDLE.
- IDLE:
  - ReqReady = 1.
  - On accept, latch ReqAddr and ReqWrite, then go to ADDR.
  - ReqReady drops in the cycle after accept.
- ADDR, 1 cycle:
  - ConCE = 0, ConADV = 0, ConAddr = latched address.
  - ConWE = ~ReqWrite, ConLB = ConUB = 0.
  - Latency counter loaded with LATENCY-1.
- LAT:
  - ConADV = 1; ConOE = 0 on reads.
  - Count down; at 0 go to DATA.
  - Write bursts: ConDataOE = 1 in the final LAT cycle and the first word is presented (WrReady = 1 only if WrValid).
- DATA, one word per cycle, with a beat counter of 0..BURST_LEN-1:
  - Read: when ConWait = 0, capture ConDataIn into RdData with RdValid = 1 in the next cycle and increment the beat. When ConWait = 1, hold the beat with RdValid = 0.
  - Write: a beat advances only when ConWait = 0 and WrValid = 1. WrReady = 1 on that cycle and ConDataOut = WrData. If WrValid = 0, drive ConLB = ConUB = 1 (byte mask) and hold the beat.
  - When the last beat completes, go to END.
- END, 1 cycle:
  - ConCE = ConOE = ConWE = 1, ConDataOE = 0.
  - Done = 1, aligned with or after the final RdValid.
  - Then IDLE. The minimum CE-high gap between bursts is 1 cycle.
- ConWait is sampled only in DATA and in the final LAT cycle.
- Address wrap: the burst stays within its aligned BURST_LEN block, matching the device's wrap mode.
- A request that arrives in END is not accepted until IDLE.
- A ReqValid held across reset is accepted only after INIT completes.

Optional Feature:
- Macro: CELLRAM_BCR_INIT_EN.
- Defined: INIT performs a 5-cycle asynchronous control-register write, then goes to IDLE:
  - ConCRE = 1, ConAddr = BCR_VALUE zero-extended, ConCE = ConADV = ConWE = 0 for 4 cycles, ConCE = 1 for 1 cycle.
  - ReqReady stays 0 throughout INIT.
- Undefined: INIT lasts 1 cycle and ConCRE is tied 0.

Test Plan:
- Release RST_N, then ReqValid with ReqWrite = 0, ReqAddr = 0x000010, ConWait = 0 (BURST_LEN 4, LATENCY 3) -> ConADV low for exactly 1 cycle, first RdValid 4 cycles after ADV, 4 consecutive RdValid, Done 1 cycle.
- Write burst at 0x000020 with WrData 0xA001..0xA004 and WrValid held high -> ConDataOut sequence matches, 4 WrReady pulses, ConDataOE low again in END.
- Read burst with ConWait asserted for 2 cycles mid-burst (beat 2) -> RdValid gap of 2 cycles, still exactly 4 words, Done delayed by 2.
- Write burst with WrValid deasserted for 1 cycle at beat 1 -> ConLB = ConUB = 1 that cycle, beat held, data order preserved.
- Assert RST_N low during DATA of a read -> all control outputs high immediately (asynchronous), no Done; recovery to IDLE after INIT.
- With CELLRAM_BCR_INIT_EN defined -> ConCRE = 1 with ConAddr = 0x08590 for 4 cycles after reset, ReqReady rises only afterwards.
